// File: rtl/peasant_pkg.sv
// Shared definitions for the peasant multiplier/divider pair: the
// handshake state encoding and the default operand width.
package peasant_pkg;

  localparam int PEASANT_NBITS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SEND = 2'd2
  } state_e;

endpackage

// File: rtl/peasant_divider_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, and subtract the divisor whenever it fits.
module div_step
  import peasant_pkg::*;
#(
  parameter int NBITS = PEASANT_NBITS
) (
  input  logic [NBITS-1:0] prem_i,
  input  logic             dividendBit_i,
  input  logic [NBITS-1:0] divisor_i,
  output logic [NBITS:0]   prem_o,
  output logic             quotBit_o
);

  logic [NBITS:0] trial;
  logic [NBITS:0] widened;

  assign trial   = {prem_i, dividendBit_i};
  assign widened = {1'b0, divisor_i};

  always_comb begin
    prem_o    = trial;
    quotBit_o = 1'b0;
    if (trial >= widened) begin
      prem_o    = trial - widened;
      quotBit_o = 1'b1;
    end
  end

endmodule

// File: rtl/peasant_divider.sv
// Restoring shift-subtract divider: 2*NBITS-bit dividend by NBITS-bit divisor,
// one quotient bit per clock, with registered iValid/iReady and oValid/oReady.
module peasant_divider
  import peasant_pkg::*;
#(
  parameter int NBITS = PEASANT_NBITS
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iValid,
  output logic               iReady,
  input  logic [2*NBITS-1:0] dividend,
  input  logic [NBITS-1:0]   divisor,
  output logic               oValid,
  input  logic               oReady,
  output logic [2*NBITS-1:0] quotient,
  output logic [NBITS-1:0]   remainder,
  output logic               divByZero
);

  localparam int QW = 2 * NBITS;
  localparam int CW = (QW > 1) ? $clog2(QW) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(QW - 1);

  state_e           state_q;
  logic [QW-1:0]    dreg_q;
  logic [QW-1:0]    quot_q;
  logic [NBITS-1:0] divisor_q;
  logic [NBITS-1:0] remainder_q;
  logic [NBITS:0]   prem_q;
  logic [CW-1:0]    count_q;
  logic             iReady_q;
  logic             oValid_q;
  logic             divByZero_q;

  logic [NBITS:0]   prem_d;
  logic             quotBit_d;
  logic [QW-1:0]    dreg_d;
  logic [QW-1:0]    quot_d;

  // The partial remainder's top bit only exists as compare headroom inside
  // div_step; after a restoring step it is always zero and is never read back.
  logic             unusedPremMsb;
  assign unusedPremMsb = prem_q[NBITS];

  div_step #(
    .NBITS(NBITS)
  ) uStep (
    .prem_i       (prem_q[NBITS-1:0]),
    .dividendBit_i(dreg_q[QW-1]),
    .divisor_i    (divisor_q),
    .prem_o       (prem_d),
    .quotBit_o    (quotBit_d)
  );

  assign dreg_d = {dreg_q[QW-2:0], 1'b0};
  assign quot_d = {quot_q[QW-2:0], quotBit_d};

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      dreg_q      <= '0;
      quot_q      <= '0;
      divisor_q   <= '0;
      remainder_q <= '0;
      prem_q      <= '0;
      count_q     <= '0;
      iReady_q    <= 1'b0;
      oValid_q    <= 1'b0;
      divByZero_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (iValid && iReady_q) begin
            iReady_q  <= 1'b0;
            dreg_q    <= dividend;
            divisor_q <= divisor;
            prem_q    <= '0;
            if (divisor != '0) begin
              quot_q  <= '0;
              count_q <= LAST_COUNT;
              state_q <= CALC;
            end else begin
              // A zero divisor skips CALC and reports an all-ones quotient.
              quot_q      <= '1;
              remainder_q <= '0;
              divByZero_q <= 1'b1;
              oValid_q    <= 1'b1;
              state_q     <= SEND;
            end
          end else begin
            iReady_q <= 1'b1;
          end
        end

        CALC: begin
          dreg_q <= dreg_d;
          prem_q <= prem_d;
          quot_q <= quot_d;
          if (count_q == '0) begin
            remainder_q <= prem_d[NBITS-1:0];
            divByZero_q <= 1'b0;
            oValid_q    <= 1'b1;
            state_q     <= SEND;
          end else begin
            count_q <= count_q - CW'(1);
          end
        end

        SEND: begin
          if (oReady) begin
            oValid_q <= 1'b0;
            iReady_q <= 1'b1;
            state_q  <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign iReady    = iReady_q;
  assign oValid    = oValid_q;
  assign quotient  = quot_q;
  assign remainder = remainder_q;
  assign divByZero = divByZero_q;

endmodule

// File: tb/tb_peasant_divider.sv
// Self-checking bench for peasant_divider: directed cases, backpressure,
// reset during CALC, then randomized operands against plain-arithmetic division.
module tb_peasant_divider;
  import peasant_pkg::*;

  localparam int NBITS = PEASANT_NBITS;
  localparam int QW    = 2 * NBITS;

  logic             clock = 1'b0;
  logic             reset;
  logic             iValid;
  logic             iReady;
  logic [QW-1:0]    dividend;
  logic [NBITS-1:0] divisor;
  logic             oValid;
  logic             oReady;
  logic [QW-1:0]    quotient;
  logic [NBITS-1:0] remainder;
  logic             divByZero;

  int testsRun     = 0;
  int failCount    = 0;
  int acceptCount  = 0;
  int resultCount  = 0;
  int overlapCount = 0;
  int opsIssued    = 0;

  peasant_divider #(
    .NBITS(NBITS)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .iValid   (iValid),
    .iReady   (iReady),
    .dividend (dividend),
    .divisor  (divisor),
    .oValid   (oValid),
    .oReady   (oReady),
    .quotient (quotient),
    .remainder(remainder),
    .divByZero(divByZero)
  );

  always #5 clock = ~clock;

  // Handshake bookkeeping, sampled with the values the DUT sees at each edge.
  always @(posedge clock) begin
    if (iValid && iReady) acceptCount++;
    if (oValid && oReady) resultCount++;
    if (iReady && oValid) overlapCount++;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One complete transaction: wait for iReady, present operands, scramble the
  // inputs while busy, check the result, hold it for holdCycles, then drain it.
  task automatic applyStimulus(input logic [QW-1:0] dvd, input logic [NBITS-1:0] dvs,
                               input int holdCycles, input bit checkLatency);
    logic [QW-1:0]    expQ;
    logic [NBITS-1:0] expR;
    logic             expZ;
    int               cycles;

    expZ = (dvs == '0);
    expQ = expZ ? {QW{1'b1}} : dvd / QW'(dvs);
    expR = expZ ? '0 : NBITS'(dvd % QW'(dvs));

    cycles = 0;
    while (!iReady && cycles < 100) begin
      tick();
      cycles++;
    end
    checkOutput("iReady before accept", 32'(iReady), 32'd1);

    iValid   = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    tick();
    iValid = 1'b0;
    opsIssued++;

    cycles = 0;
    while (!oValid && cycles < 100) begin
      dividend = QW'($urandom);
      divisor  = NBITS'($urandom);
      iValid   = 1'($urandom);
      tick();
      cycles++;
    end
    iValid = 1'b0;

    checkOutput("oValid arrives", 32'(oValid), 32'd1);
    if (checkLatency) checkOutput("latency", 32'(cycles), expZ ? 32'd0 : 32'(QW));
    checkOutput("iReady low while oValid", 32'(iReady), 32'd0);
    checkOutput("quotient", 32'(quotient), 32'(expQ));
    checkOutput("remainder", 32'(remainder), 32'(expR));
    checkOutput("divByZero", 32'(divByZero), 32'(expZ));
    if (!expZ) begin
      checkOutput("q*d+r", 32'(quotient) * 32'(dvs) + 32'(remainder), 32'(dvd));
      checkOutput("remainder below divisor", 32'(remainder < dvs), 32'd1);
    end

    for (int i = 0; i < holdCycles; i++) begin
      tick();
      checkOutput("hold oValid", 32'(oValid), 32'd1);
      checkOutput("hold quotient", 32'(quotient), 32'(expQ));
      checkOutput("hold remainder", 32'(remainder), 32'(expR));
      checkOutput("hold divByZero", 32'(divByZero), 32'(expZ));
    end

    oReady = 1'b1;
    tick();
    oReady = 1'b0;
    checkOutput("oValid drops", 32'(oValid), 32'd0);
    checkOutput("iReady returns", 32'(iReady), 32'd1);
  endtask

  initial begin
    logic [QW-1:0]    rDvd;
    logic [NBITS-1:0] rDvs;

    reset    = 1'b0;
    iValid   = 1'b0;
    oReady   = 1'b0;
    dividend = '0;
    divisor  = '0;

    repeat (3) tick();
    checkOutput("reset iReady", 32'(iReady), 32'd0);
    checkOutput("reset oValid", 32'(oValid), 32'd0);
    checkOutput("reset quotient", 32'(quotient), 32'd0);
    checkOutput("reset remainder", 32'(remainder), 32'd0);
    checkOutput("reset divByZero", 32'(divByZero), 32'd0);

    reset = 1'b1;
    tick();
    checkOutput("iReady after release", 32'(iReady), 32'd1);

    applyStimulus(16'd132, 8'd11, 0, 1'b1);
    applyStimulus(16'd100, 8'd7, 0, 1'b1);
    applyStimulus(16'd5, 8'd9, 0, 1'b1);
    applyStimulus(16'd65535, 8'd1, 0, 1'b1);
    applyStimulus(16'd500, 8'd0, 0, 1'b1);
    applyStimulus(16'd100, 8'd7, 5, 1'b1);

    // Reset lands on the sixth CALC edge of a 65535/1 division.
    checkOutput("iReady before dropped op", 32'(iReady), 32'd1);
    iValid   = 1'b1;
    dividend = 16'd65535;
    divisor  = 8'd1;
    tick();
    iValid = 1'b0;
    repeat (5) tick();
    reset = 1'b0;
    tick();
    checkOutput("midcalc reset iReady", 32'(iReady), 32'd0);
    checkOutput("midcalc reset oValid", 32'(oValid), 32'd0);
    checkOutput("midcalc reset quotient", 32'(quotient), 32'd0);
    checkOutput("midcalc reset remainder", 32'(remainder), 32'd0);
    checkOutput("midcalc reset divByZero", 32'(divByZero), 32'd0);
    reset = 1'b1;
    tick();
    checkOutput("iReady after midcalc release", 32'(iReady), 32'd1);
    repeat (20) tick();
    checkOutput("dropped op gives no result", 32'(oValid), 32'd0);
    applyStimulus(16'd200, 8'd3, 0, 1'b1);

    for (int n = 0; n < 1000; n++) begin
      rDvd = QW'($urandom);
      rDvs = ($urandom_range(0, 15) == 0) ? '0 : NBITS'($urandom);
      repeat ($urandom_range(0, 3)) tick();
      applyStimulus(rDvd, rDvs, $urandom_range(0, 3), 1'b1);
    end

    repeat (3) tick();
    checkOutput("accepts seen", 32'(acceptCount), 32'(opsIssued + 1));
    checkOutput("results seen", 32'(resultCount), 32'(opsIssued));
    checkOutput("iReady and oValid overlap", 32'(overlapCount), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
